// File: rtl/seq_mul_16_bit_pkg.sv
// Shared constants, state encoding and helpers for the 16x16 shift-and-add multiplier.
// Optional feature macro: SEQ_MUL_EARLY_TERM_EN (zero-operand early termination).
package seq_mul_pkg;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic is_last_iter(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(ITER - 1));
    endfunction

endpackage

// File: rtl/seq_mul_16_bit_if.sv
// Start/busy/done handshake and operand/product bus between ALU control and the MUL unit.
// Optional feature macro: SEQ_MUL_EARLY_TERM_EN (no effect on this interface).
interface seq_mul_16_bit_if;
    import seq_mul_pkg::*;

    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/seq_mul_16_bit_cla.sv
// 16-bit carry look-ahead adder: four 4-bit groups with group propagate/generate lookahead.
// Optional feature macro: SEQ_MUL_EARLY_TERM_EN (no effect on this module).
module cla_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out,
    output logic        P,
    output logic        G
);

    logic [15:0] p_s;
    logic [15:0] g_s;
    logic [3:0]  gp_s;
    logic [3:0]  gg_s;
    logic [4:0]  gc_s;
    logic [16:0] c_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Group propagate/generate for each 4-bit slice.
    always_comb begin
        gp_s = 4'b0000;
        gg_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            gp_s[i] = &p_s[4*i +: 4];
            gg_s[i] = g_s[4*i+3]
                    | (p_s[4*i+3] & g_s[4*i+2])
                    | (p_s[4*i+3] & p_s[4*i+2] & g_s[4*i+1])
                    | (p_s[4*i+3] & p_s[4*i+2] & p_s[4*i+1] & g_s[4*i]);
        end
    end

    // Carries into each group are flattened so no group waits on its neighbour.
    always_comb begin
        gc_s[0] = c_in;
        gc_s[1] = gg_s[0] | (gp_s[0] & c_in);
        gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & c_in);
        gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[2] & gp_s[1] & gp_s[0] & c_in);
        gc_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & c_in);
    end

    // Bit carries inside each group, seeded by the group carry.
    always_comb begin
        c_s = 17'd0;
        for (int i = 0; i < 4; i++) begin
            c_s[4*i] = gc_s[i];
            for (int j = 0; j < 3; j++) begin
                c_s[4*i+j+1] = g_s[4*i+j] | (p_s[4*i+j] & c_s[4*i+j]);
            end
        end
        c_s[16] = gc_s[4];
    end

    assign sum   = p_s ^ c_s[15:0];
    assign c_out = c_s[16];
    assign P     = &gp_s;
    assign G     = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                 | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0]);

endmodule

// File: rtl/seq_mul_16_bit.sv
// Multi-cycle 16x16 unsigned shift-and-add MUL unit driving the CLA adder once per iteration.
// Optional feature macro: SEQ_MUL_EARLY_TERM_EN (zero operand finishes in one cycle).
module seq_mul_16_bit #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    seq_mul_16_bit_if.slave bus
);
    import seq_mul_pkg::*;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [2*WIDTH-1:0]     product_q, product_d;
    logic [WIDTH-1:0]       cla_sum_s;
    logic                   cla_cout_s;

    cla_16_bit u_cla (
        .a     (hi_q),
        .b     (mcand_q),
        .c_in  (1'b0),
        .sum   (cla_sum_s),
        .c_out (cla_cout_s),
        .P     (),
        .G     ()
    );

    // State and handshake output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef SEQ_MUL_EARLY_TERM_EN
                    if ((bus.a == 16'h0000) || (bus.b == 16'h0000)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (is_last_iter(count_q)) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they are registered alongside it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
            RUN: begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, one add-and-shift per RUN cycle, product capture on the last one.
    always_comb begin
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    hi_d    = 16'h0000;
                    lo_d    = bus.b;
                    count_d = CNT_W'(0);
`ifdef SEQ_MUL_EARLY_TERM_EN
                    if ((bus.a == 16'h0000) || (bus.b == 16'h0000)) begin
                        product_d = 32'h0000_0000;
                    end else begin
                        product_d = product_q;
                    end
`endif
                end else begin
                    count_d = count_q;
                end
            end
            RUN: begin
                // The adder carry lands in hi[15]; nothing is ever dropped.
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {cla_cout_s, cla_sum_s, lo_q[WIDTH-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
                end
                count_d = count_q + CNT_W'(1);
                if (is_last_iter(count_q)) begin
                    product_d = {hi_d, lo_d};
                end else begin
                    product_d = product_q;
                end
            end
            DONE: begin
                count_d = count_q;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= 16'h0000;
            hi_q      <= 16'h0000;
            lo_q      <= 16'h0000;
            count_q   <= CNT_W'(0);
            product_q <= 32'h0000_0000;
        end else begin
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: doc/seq_mul_16_bit.md
# seq_mul_16_bit

Sequential 16x16 unsigned shift-and-add multiplier producing a 32-bit product. It sits directly upstream of the 16-bit carry look-ahead adder in the ALU datapath. Each iteration drives the adder with the running partial product and the multiplicand, then registers its sum and carry-out. The block is the multi-cycle MUL unit; a start/busy/done handshake connects it to the ALU control.

## Interface
Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH. Only 16 is supported.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  16  multiplicand, captured when start is accepted
- b  input  16  multiplier, captured when start is accepted
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; product valid in that cycle
- product  output  32  result register; holds until overwritten by the next completed multiply

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, busy=0, done=0, product=0, iteration count=0, accumulator registers=0.
- IDLE:
  - On start=1: mcand<=a, hi<=16'h0000, lo<=b, count<=0, go to RUN.
  - On start=0: stay in IDLE.
- RUN, each cycle:
  - The adder computes {c,s} = hi + mcand with c_in=0.
  - If lo[0]=1: {hi,lo} <= {c,s,lo[15:1]}.
  - Otherwise: {hi,lo} <= {1'b0,hi,lo[15:1]}.
  - Then count<=count+1.
  - After the iteration in which count==15, go to DONE and product <= the post-shift {hi,lo}.
- DONE: done=1 for exactly one cycle, then go to IDLE. The product register is not modified.
- Arithmetic is unsigned and modulo-free: the 32-bit product is always exact. The adder carry-out is never dropped; it becomes hi[15] after the shift.
- start while busy=1 is ignored. No queueing, and a, b and the internal registers are unaffected.
- start in the DONE cycle is ignored. The next start is accepted in IDLE.
- a and b may change freely after acceptance.
- rst at any state, including mid-RUN, returns to IDLE next edge with all reset values, product=0, and no done pulse. The aborted operation is discarded.

## Timing
- start accepted at edge T:
  - RUN occupies edges T+1 through T+16.
  - done=1 and product is valid in the cycle after edge T+16, i.e. registered at T+17.
- Latency: 17 cycles from the accepting edge to done.
- Minimum start-to-start interval: 18 cycles.
- busy rises the cycle after acceptance and falls together with done.
- The adder path is combinational within one cycle. hi, lo, c and count are registered; the product output is registered.

## Configuration
- Macro: SEQ_MUL_EARLY_TERM_EN.
- Defined:
  - A start accepted with a==0 or b==0 goes IDLE -> DONE directly, skipping RUN.
  - product<=0 and done pulses in the cycle after acceptance, for a latency of 1.
  - busy is high only in that DONE cycle.
- Undefined: every multiply takes the full 16 iterations, zero operands included.

## Structure
- Shared package seq_mul_pkg holds:
  - the WIDTH=16 constant and ITER=16
  - state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10
- One sub-module instance, cla_16_bit, with these connections:
  - a=hi, b=mcand, c_in=1'b0
  - sum and c_out used as described in Operation
  - P and G left unconnected
- FSM, counter and shift registers live in this block; there are no further sub-modules.

## Test plan
- Basic: start with a=16'd3, b=16'd5 -> done pulse exactly 17 cycles after acceptance, product=32'd15, busy high for 17 cycles.
- Max operands: a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001. This exercises c_out=1 propagating into hi[15].
- Ignored start: start with a=16'h1234, b=16'h0010, then pulse start with a=16'hFFFF, b=16'hFFFF at cycle 5 of RUN -> single done pulse, product=32'h00012340.
- Reset mid-run: start with a=16'h00FF, b=16'h00FF, assert rst at cycle 8 of RUN -> next cycle state IDLE, busy=0, product=0, no done for at least 20 cycles. A new start with 7*9 then gives 32'd63.
- Zero operand: a=16'h0000, b=16'hABCD -> with SEQ_MUL_EARLY_TERM_EN, done 1 cycle after acceptance with product=0; without it, done after 17 cycles with product=0.
- Back-to-back: start held high continuously with a=16'd100, b=16'd200 -> done pulses 18 cycles apart, each with product=32'd20000, and product stable between pulses.
